scr_base_l3_bk_rob_q: RTL and testbench

//  Parametrised L3 bank request-ongoing buffer. Sits after bank pipeline stage d4.

---
 rtl/scr_base_l3_bk_rob_pkg.sv | 40 ++++
 rtl/scr_base_l3_bk_rob_q_if.sv | 56 +++++
 rtl/scr_base_l3_bk_rr_arb.sv | 76 +++++++
 rtl/scr_base_l3_bk_rob_q.sv | 144 ++++++++++++++
 tb/tb_scr_base_l3_bk_rob_q.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/scr_base_l3_bk_rob_pkg.sv
// Shared types for the L3 bank request-ongoing buffer.
// Holds the action bit positions, the per-entry state record and the
// free-slot search helper. The entry record is sized from the package
// localparams below, so the top-level DEPTH/ADDR_W parameters must match them.
package scr_base_l3_bk_rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_ADDR_W = 32;
  localparam int ROB_FLIT_W = 64;
  localparam int ROB_PTR_W  = $clog2(ROB_DEPTH);

  localparam int ROB_ACT_LDWR = 0;
  localparam int ROB_ACT_REQ  = 1;
  localparam int ROB_ACT_SNP  = 2;

  typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

  typedef struct packed {
    logic                  val;
    logic                  first;       // chain head: allowed to issue actions
    logic                  last;        // chain tail: no successor
    rob_ptr_t              next;        // successor index when last == 0
    logic [ROB_ADDR_W-1:0] addr;
    logic [2:0]            act;         // outstanding actions
    logic                  wack;        // must see a completion ack before retiring
    logic                  ack_seen;
    logic                  retry_pend;  // promoted head still waiting for its replay
  } rob_entry_t;

  // Lowest index whose bit is 0; returns 0 when every bit is set.
  function automatic rob_ptr_t rob_ffz(input logic [ROB_DEPTH-1:0] vec);
    rob_ptr_t idx;
    idx = '0;
    for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
      idx = vec[i] ? idx : rob_ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scr_base_l3_bk_rob_q_if.sv
// Bus bundle between the bank pipeline and the ROB.
// Signal names carry the ROB's point of view (_i into the ROB, _o out of it).
//   slave  : ROB side (lookup/alloc/ack/ready in, results and channel payloads out)
//   master : pipeline / downstream side
interface scr_base_l3_bk_rob_q_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int FLIT_W = 64
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              lk_val_i;
  logic [ADDR_W-1:0] lk_addr_i;
  logic              lk_hit_o;
  logic [PTR_W-1:0]  lk_tail_o;
  logic              al_val_i;
  logic [ADDR_W-1:0] al_addr_i;
  logic [2:0]        al_act_i;
  logic              al_wack_i;
  logic [FLIT_W-1:0] al_flit_i;
  logic              al_full_o;
  logic [PTR_W-1:0]  al_idx_o;
  logic              ldwr_val_o;
  logic [PTR_W-1:0]  ldwr_idx_o;
  logic [ADDR_W-1:0] ldwr_addr_o;
  logic              ldwr_ready_i;
  logic              req_val_o;
  logic [FLIT_W-1:0] req_flit_o;
  logic              req_ready_i;
  logic              snp_val_o;
  logic [FLIT_W-1:0] snp_flit_o;
  logic              snp_ready_i;
  logic              retry_val_o;
  logic [PTR_W-1:0]  retry_idx_o;
  logic [ADDR_W-1:0] retry_addr_o;
  logic              retry_ready_i;
  logic              ack_val_i;
  logic [PTR_W-1:0]  ack_idx_i;
  logic              err_o;

  modport slave (
    input  lk_val_i, lk_addr_i, al_val_i, al_addr_i, al_act_i, al_wack_i, al_flit_i,
           ldwr_ready_i, req_ready_i, snp_ready_i, retry_ready_i, ack_val_i, ack_idx_i,
    output lk_hit_o, lk_tail_o, al_full_o, al_idx_o, ldwr_val_o, ldwr_idx_o, ldwr_addr_o,
           req_val_o, req_flit_o, snp_val_o, snp_flit_o, retry_val_o, retry_idx_o,
           retry_addr_o, err_o
  );

  modport master (
    output lk_val_i, lk_addr_i, al_val_i, al_addr_i, al_act_i, al_wack_i, al_flit_i,
           ldwr_ready_i, req_ready_i, snp_ready_i, retry_ready_i, ack_val_i, ack_idx_i,
    input  lk_hit_o, lk_tail_o, al_full_o, al_idx_o, ldwr_val_o, ldwr_idx_o, ldwr_addr_o,
           req_val_o, req_flit_o, snp_val_o, snp_flit_o, retry_val_o, retry_idx_o,
           retry_addr_o, err_o
  );
endinterface

// File: rtl/scr_base_l3_bk_rr_arb.sv
// Round-robin arbiter with lock-on-stall.
// Ports: clk, rst; req_i (DEPTH requesters); ready_i (downstream accept);
//        gnt_val_o / gnt_idx_o / gnt_o (valid, index, one-hot grant).
// A grant offered without ready is held on the next cycle so the payload stays
// stable; after a handshake the search restarts just past the granted index.
module scr_base_l3_bk_rr_arb #(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] req_i,
  input  logic             ready_i,
  output logic             gnt_val_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic [DEPTH-1:0] gnt_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
  logic             rr_found;
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] cand;

  // rotating-priority search starting at ptr_q (index wraps modulo DEPTH)
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      cand     = ptr_q + PTR_W'(i);
      rr_idx   = (!rr_found && req_i[cand]) ? cand : rr_idx;
      rr_found = rr_found | req_i[cand];
    end
  end

  // grant: a held grant wins while its requester still asks
  always_comb begin
    if (lock_q && req_i[lock_idx_q]) begin
      gnt_val_o = 1'b1;
      gnt_idx_o = lock_idx_q;
    end else begin
      gnt_val_o = rr_found;
      gnt_idx_o = rr_idx;
    end
    gnt_o = gnt_val_o ? (DEPTH'(1) << gnt_idx_o) : '0;
  end

  // pointer advance on handshake, lock on stall
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (gnt_val_o && ready_i) begin
      ptr_d = gnt_idx_o + PTR_W'(1);
    end else if (gnt_val_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx_o;
    end else begin
      lock_d = 1'b0;
    end
  end

  // arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: rtl/scr_base_l3_bk_rob_q.sv
// L3 bank request-ongoing buffer (after pipeline stage d4).
// Ports: clk, rst (async, active-high); bus (slave modport) carrying lookup,
// allocate, LDWR/REQ/SNP/retry issue channels, completion ack and sticky err.
// Same-address entries form a chain; only the chain head issues actions, and
// when a head retires its successor is promoted and replayed on the retry channel.
module scr_base_l3_bk_rob_q
  import scr_base_l3_bk_rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int ADDR_W = ROB_ADDR_W,
  parameter int FLIT_W = ROB_FLIT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  scr_base_l3_bk_rob_q_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  rob_entry_t        entry_q [DEPTH];
  rob_entry_t        entry_d [DEPTH];
  logic [FLIT_W-1:0] flit_q  [DEPTH];
  logic [FLIT_W-1:0] flit_d  [DEPTH];
  logic              err_q, err_d;
  logic              lk_hit_q, lk_hit_d;
  logic [PTR_W-1:0]  lk_tail_q, lk_tail_d;

  logic [DEPTH-1:0]  val_vec, retire_vec, succ_vec;
  logic [DEPTH-1:0]  ldwr_req, req_req, snp_req, retry_req;
  logic [DEPTH-1:0]  ldwr_gnt, req_gnt, snp_gnt, retry_gnt;
  logic              ldwr_gval, req_gval, snp_gval, retry_gval;
  logic [PTR_W-1:0]  ldwr_gidx, req_gidx, snp_gidx, retry_gidx;
  logic [PTR_W-1:0]  free_idx, al_tail_idx;
  logic              al_tail_hit, al_ok, al_link;
  rob_entry_t        al_entry;

  // per-entry status from registered state; a retiring head must be first in its chain
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      val_vec[i]    = entry_q[i].val;
      ldwr_req[i]   = entry_q[i].val & entry_q[i].first & ~entry_q[i].retry_pend & entry_q[i].act[ROB_ACT_LDWR];
      req_req[i]    = entry_q[i].val & entry_q[i].first & ~entry_q[i].retry_pend & entry_q[i].act[ROB_ACT_REQ];
      snp_req[i]    = entry_q[i].val & entry_q[i].first & ~entry_q[i].retry_pend & entry_q[i].act[ROB_ACT_SNP];
      retry_req[i]  = entry_q[i].val & entry_q[i].retry_pend;
      retire_vec[i] = entry_q[i].val & entry_q[i].first & (entry_q[i].act == 3'b000) &
                      (~entry_q[i].wack | entry_q[i].ack_seen) & ~entry_q[i].retry_pend;
    end
    for (int j = 0; j < DEPTH; j++) begin
      succ_vec[j] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        succ_vec[j] = succ_vec[j] | (retire_vec[i] & ~entry_q[i].last & (entry_q[i].next == PTR_W'(j)));
      end
    end
  end

  // address matches for the allocation tail and the d1 lookup
  always_comb begin
    al_tail_hit = 1'b0;
    al_tail_idx = '0;
    lk_hit_d    = 1'b0;
    lk_tail_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      al_tail_idx = (entry_q[i].val && entry_q[i].last && entry_q[i].addr == bus.al_addr_i) ? PTR_W'(i) : al_tail_idx;
      al_tail_hit = al_tail_hit | (entry_q[i].val & entry_q[i].last & (entry_q[i].addr == bus.al_addr_i));
      lk_tail_d   = (bus.lk_val_i && entry_q[i].val && entry_q[i].last && entry_q[i].addr == bus.lk_addr_i) ? PTR_W'(i) : lk_tail_d;
      lk_hit_d    = lk_hit_d | (bus.lk_val_i & entry_q[i].val & (entry_q[i].addr == bus.lk_addr_i));
    end
  end

  // next-state: handshakes, acks, retire/promotion, then allocation overwrites its slot
  always_comb begin
    free_idx = rob_ffz(val_vec);
    al_ok    = bus.al_val_i & ~(&val_vec);
    // a tail retiring this cycle cannot be linked; the new entry starts its own chain
    al_link  = al_ok & al_tail_hit & ~retire_vec[al_tail_idx];
    al_entry = '{val: 1'b1, first: ~al_link, last: 1'b1, next: '0, addr: bus.al_addr_i,
                 act: bus.al_act_i, wack: bus.al_wack_i, ack_seen: 1'b0, retry_pend: 1'b0};
    err_d    = err_q | (bus.al_val_i & (&val_vec)) | (bus.ack_val_i & ~val_vec[bus.ack_idx_i]);
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      entry_d[i].act[ROB_ACT_LDWR] = entry_q[i].act[ROB_ACT_LDWR] & ~(ldwr_gnt[i] & bus.ldwr_ready_i);
      entry_d[i].act[ROB_ACT_REQ]  = entry_q[i].act[ROB_ACT_REQ]  & ~(req_gnt[i]  & bus.req_ready_i);
      entry_d[i].act[ROB_ACT_SNP]  = entry_q[i].act[ROB_ACT_SNP]  & ~(snp_gnt[i]  & bus.snp_ready_i);
      entry_d[i].retry_pend = (entry_q[i].retry_pend & ~(retry_gnt[i] & bus.retry_ready_i)) | succ_vec[i];
      entry_d[i].first      = entry_q[i].first | succ_vec[i];
      entry_d[i].ack_seen   = entry_q[i].ack_seen | (bus.ack_val_i & entry_q[i].val & (bus.ack_idx_i == PTR_W'(i)));
      entry_d[i].val        = entry_q[i].val & ~retire_vec[i];
      entry_d[i].next       = (al_link && al_tail_idx == PTR_W'(i)) ? free_idx : entry_q[i].next;
      entry_d[i].last       = entry_q[i].last & ~(al_link && al_tail_idx == PTR_W'(i));
      entry_d[i] = (al_ok && free_idx == PTR_W'(i)) ? al_entry : entry_d[i];
      flit_d[i]  = (al_ok && free_idx == PTR_W'(i)) ? bus.al_flit_i : flit_q[i];
    end
  end

  // entry state, stored flits, sticky error and registered lookup result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        flit_q[i]  <= '0;
      end
      err_q     <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_tail_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
        flit_q[i]  <= flit_d[i];
      end
      err_q     <= err_d;
      lk_hit_q  <= lk_hit_d;
      lk_tail_q <= lk_tail_d;
    end
  end

  scr_base_l3_bk_rr_arb #(.DEPTH(DEPTH)) u_arb_ldwr (
    .clk(clk), .rst(rst), .req_i(ldwr_req), .ready_i(bus.ldwr_ready_i),
    .gnt_val_o(ldwr_gval), .gnt_idx_o(ldwr_gidx), .gnt_o(ldwr_gnt));
  scr_base_l3_bk_rr_arb #(.DEPTH(DEPTH)) u_arb_req (
    .clk(clk), .rst(rst), .req_i(req_req), .ready_i(bus.req_ready_i),
    .gnt_val_o(req_gval), .gnt_idx_o(req_gidx), .gnt_o(req_gnt));
  scr_base_l3_bk_rr_arb #(.DEPTH(DEPTH)) u_arb_snp (
    .clk(clk), .rst(rst), .req_i(snp_req), .ready_i(bus.snp_ready_i),
    .gnt_val_o(snp_gval), .gnt_idx_o(snp_gidx), .gnt_o(snp_gnt));
  scr_base_l3_bk_rr_arb #(.DEPTH(DEPTH)) u_arb_retry (
    .clk(clk), .rst(rst), .req_i(retry_req), .ready_i(bus.retry_ready_i),
    .gnt_val_o(retry_gval), .gnt_idx_o(retry_gidx), .gnt_o(retry_gnt));

  // outputs derive only from registers; payloads are zero when no grant is offered
  assign bus.lk_hit_o     = lk_hit_q;
  assign bus.lk_tail_o    = lk_tail_q;
  assign bus.al_full_o    = &val_vec;
  assign bus.al_idx_o     = free_idx;
  assign bus.err_o        = err_q;
  assign bus.ldwr_val_o   = ldwr_gval;
  assign bus.ldwr_idx_o   = ldwr_gval ? ldwr_gidx : '0;
  assign bus.ldwr_addr_o  = ldwr_gval ? entry_q[ldwr_gidx].addr : '0;
  assign bus.req_val_o    = req_gval;
  assign bus.req_flit_o   = req_gval ? flit_q[req_gidx] : '0;
  assign bus.snp_val_o    = snp_gval;
  assign bus.snp_flit_o   = snp_gval ? flit_q[snp_gidx] : '0;
  assign bus.retry_val_o  = retry_gval;
  assign bus.retry_idx_o  = retry_gval ? retry_gidx : '0;
  assign bus.retry_addr_o = retry_gval ? entry_q[retry_gidx].addr : '0;
endmodule

// File: tb/tb_scr_base_l3_bk_rob_q.sv
// Directed bench for scr_base_l3_bk_rob_q: reset, single alloc with lookup,
// same-address chain with retry, REQ backpressure, full buffer, early ack, SNP.
module tb_scr_base_l3_bk_rob_q;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scr_base_l3_bk_rob_q_if #(.DEPTH(16), .ADDR_W(32), .FLIT_W(64)) bus ();

  scr_base_l3_bk_rob_q #(.DEPTH(16), .ADDR_W(32), .FLIT_W(64)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lk_val_i = 1'b0;       bus.lk_addr_i = 32'h0;
    bus.al_val_i = 1'b0;       bus.al_addr_i = 32'h0;  bus.al_act_i = 3'b000;
    bus.al_wack_i = 1'b0;      bus.al_flit_i = 64'h0;
    bus.ldwr_ready_i = 1'b0;   bus.req_ready_i = 1'b0;
    bus.snp_ready_i = 1'b0;    bus.retry_ready_i = 1'b0;
    bus.ack_val_i = 1'b0;      bus.ack_idx_i = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [2:0] act, input logic wack, input logic [63:0] f);
    bus.al_val_i = 1'b1; bus.al_addr_i = a; bus.al_act_i = act;
    bus.al_wack_i = wack; bus.al_flit_i = f;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_ldwr_val", 64'(bus.ldwr_val_o), 64'd0);
    chk("rst_req_val", 64'(bus.req_val_o), 64'd0);
    chk("rst_snp_val", 64'(bus.snp_val_o), 64'd0);
    chk("rst_retry_val", 64'(bus.retry_val_o), 64'd0);
    chk("rst_full", 64'(bus.al_full_o), 64'd0);
    chk("rst_idx", 64'(bus.al_idx_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_lk_hit", 64'(bus.lk_hit_o), 64'd0);

    // single alloc with ldwr+req and wack; same-cycle lookup must miss
    alloc(32'h100, 3'b011, 1'b1, 64'hF1F1_0000_0000_0100);
    bus.lk_val_i = 1'b1; bus.lk_addr_i = 32'h100;
    cyc();
    bus.al_val_i = 1'b0;
    chk("s_lk_same_cycle", 64'(bus.lk_hit_o), 64'd0);
    chk("s_ldwr_val", 64'(bus.ldwr_val_o), 64'd1);
    chk("s_ldwr_idx", 64'(bus.ldwr_idx_o), 64'd0);
    chk("s_ldwr_addr", 64'(bus.ldwr_addr_o), 64'h100);
    chk("s_req_val", 64'(bus.req_val_o), 64'd1);
    chk("s_req_flit", bus.req_flit_o, 64'hF1F1_0000_0000_0100);
    chk("s_snp_val", 64'(bus.snp_val_o), 64'd0);
    chk("s_al_idx", 64'(bus.al_idx_o), 64'd1);
    cyc();
    chk("s_lk_hit", 64'(bus.lk_hit_o), 64'd1);
    chk("s_lk_tail", 64'(bus.lk_tail_o), 64'd0);
    bus.lk_addr_i = 32'h104;
    cyc();
    bus.lk_val_i = 1'b0;
    chk("s_lk_miss", 64'(bus.lk_hit_o), 64'd0);
    bus.ldwr_ready_i = 1'b1; bus.req_ready_i = 1'b1;
    cyc();
    bus.ldwr_ready_i = 1'b0; bus.req_ready_i = 1'b0;
    chk("s_ldwr_done", 64'(bus.ldwr_val_o), 64'd0);
    chk("s_req_done", 64'(bus.req_val_o), 64'd0);
    chk("s_wait_ack", 64'(bus.al_idx_o), 64'd1);
    bus.ack_val_i = 1'b1; bus.ack_idx_i = 4'd0;
    cyc();
    bus.ack_val_i = 1'b0;
    chk("s_ack_retiring", 64'(bus.al_idx_o), 64'd1);
    cyc();
    chk("s_freed", 64'(bus.al_idx_o), 64'd0);
    chk("s_err", 64'(bus.err_o), 64'd0);

    // chain of three same-address entries, REQ only
    do_reset();
    alloc(32'h200, 3'b010, 1'b0, 64'hA0);
    cyc();
    alloc(32'h200, 3'b010, 1'b0, 64'hA1);
    cyc();
    alloc(32'h200, 3'b010, 1'b0, 64'hA2);
    cyc();
    bus.al_val_i = 1'b0;
    chk("c_req0_val", 64'(bus.req_val_o), 64'd1);
    chk("c_req0_flit", bus.req_flit_o, 64'hA0);
    bus.req_ready_i = 1'b1;
    cyc();
    bus.req_ready_i = 1'b0;
    chk("c_no_req_succ", 64'(bus.req_val_o), 64'd0);
    chk("c_no_retry_yet", 64'(bus.retry_val_o), 64'd0);
    cyc();
    chk("c_retry1_val", 64'(bus.retry_val_o), 64'd1);
    chk("c_retry1_idx", 64'(bus.retry_idx_o), 64'd1);
    chk("c_retry1_addr", 64'(bus.retry_addr_o), 64'h200);
    chk("c_req_blocked", 64'(bus.req_val_o), 64'd0);
    bus.retry_ready_i = 1'b1;
    cyc();
    bus.retry_ready_i = 1'b0;
    chk("c_retry1_done", 64'(bus.retry_val_o), 64'd0);
    chk("c_req1_val", 64'(bus.req_val_o), 64'd1);
    chk("c_req1_flit", bus.req_flit_o, 64'hA1);
    bus.req_ready_i = 1'b1;
    cyc();
    bus.req_ready_i = 1'b0;
    chk("c_req1_done", 64'(bus.req_val_o), 64'd0);
    cyc();
    chk("c_retry2_val", 64'(bus.retry_val_o), 64'd1);
    chk("c_retry2_idx", 64'(bus.retry_idx_o), 64'd2);
    bus.retry_ready_i = 1'b1;
    cyc();
    bus.retry_ready_i = 1'b0;
    chk("c_req2_flit", bus.req_flit_o, 64'hA2);
    bus.req_ready_i = 1'b1;
    cyc();
    bus.req_ready_i = 1'b0;
    cyc();
    bus.lk_val_i = 1'b1; bus.lk_addr_i = 32'h200;
    cyc();
    bus.lk_val_i = 1'b0;
    chk("c_all_gone", 64'(bus.lk_hit_o), 64'd0);

    // REQ backpressure across three independent heads
    do_reset();
    alloc(32'h300, 3'b010, 1'b0, 64'hB0);
    cyc();
    alloc(32'h340, 3'b010, 1'b0, 64'hB1);
    cyc();
    alloc(32'h380, 3'b010, 1'b0, 64'hB2);
    cyc();
    bus.al_val_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("b_stall_flit", bus.req_flit_o, 64'hB0);
      cyc();
    end
    bus.req_ready_i = 1'b1;
    cyc();
    chk("b_second", bus.req_flit_o, 64'hB1);
    cyc();
    chk("b_third", bus.req_flit_o, 64'hB2);
    cyc();
    chk("b_drained", 64'(bus.req_val_o), 64'd0);
    bus.req_ready_i = 1'b0;

    // fill all 16 entries, overflow, free idx5 and reuse it
    do_reset();
    for (int k = 0; k < 16; k++) begin
      alloc(32'h1000 + 32'(k) * 32'h40, 3'b000, 1'b1, 64'(k));
      chk("f_idx", 64'(bus.al_idx_o), 64'(k));
      cyc();
    end
    chk("f_full", 64'(bus.al_full_o), 64'd1);
    chk("f_err_clear", 64'(bus.err_o), 64'd0);
    alloc(32'h9000, 3'b000, 1'b1, 64'h0);
    cyc();
    bus.al_val_i = 1'b0;
    chk("f_overflow_err", 64'(bus.err_o), 64'd1);
    chk("f_still_full", 64'(bus.al_full_o), 64'd1);
    bus.ack_val_i = 1'b1; bus.ack_idx_i = 4'd5;
    cyc();
    bus.ack_val_i = 1'b0;
    chk("f_full_until_retire", 64'(bus.al_full_o), 64'd1);
    cyc();
    chk("f_not_full", 64'(bus.al_full_o), 64'd0);
    chk("f_reuse_idx", 64'(bus.al_idx_o), 64'd5);
    alloc(32'h2000, 3'b000, 1'b1, 64'h0);
    cyc();
    bus.al_val_i = 1'b0;
    chk("f_refull", 64'(bus.al_full_o), 64'd1);

    // early ack before REQ handshake, then ack to a freed slot
    do_reset();
    alloc(32'h500, 3'b010, 1'b1, 64'hC0);
    cyc();
    bus.al_val_i = 1'b0;
    bus.ack_val_i = 1'b1; bus.ack_idx_i = 4'd0;
    cyc();
    bus.ack_val_i = 1'b0;
    chk("e_req_pending", 64'(bus.req_val_o), 64'd1);
    chk("e_held", 64'(bus.al_idx_o), 64'd1);
    chk("e_err_clear", 64'(bus.err_o), 64'd0);
    bus.req_ready_i = 1'b1;
    cyc();
    bus.req_ready_i = 1'b0;
    chk("e_req_done", 64'(bus.req_val_o), 64'd0);
    chk("e_retiring", 64'(bus.al_idx_o), 64'd1);
    cyc();
    chk("e_freed", 64'(bus.al_idx_o), 64'd0);
    bus.ack_val_i = 1'b1; bus.ack_idx_i = 4'd0;
    cyc();
    bus.ack_val_i = 1'b0;
    chk("e_bad_ack_err", 64'(bus.err_o), 64'd1);

    // SNP channel
    do_reset();
    alloc(32'h600, 3'b100, 1'b0, 64'h5A5A_0000_0000_0600);
    cyc();
    bus.al_val_i = 1'b0;
    chk("n_snp_val", 64'(bus.snp_val_o), 64'd1);
    chk("n_snp_flit", bus.snp_flit_o, 64'h5A5A_0000_0000_0600);
    chk("n_req_val", 64'(bus.req_val_o), 64'd0);
    bus.snp_ready_i = 1'b1;
    cyc();
    bus.snp_ready_i = 1'b0;
    chk("n_snp_done", 64'(bus.snp_val_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
